// File: rtl/w21_col_mac_seq_if.sv
// ============================================================================
// Module  : w21_col_mac_seq_if
// Brief   : Control, weight-ROM, activation and result bus of the W21 column MAC.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface w21_col_mac_seq_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 21,
    parameter int ACC_W  = 51
);
    logic                     start;
    logic                     abort;
    logic                     busy;
    logic [ADDR_W-1:0]        rom_adrs;
    logic signed [DATA_W-1:0] rom_data;
    logic signed [DATA_W-1:0] act_data;
    logic                     act_valid;
    logic                     act_ready;
    logic signed [ACC_W-1:0]  res_data;
    logic                     res_valid;
    logic                     res_ready;

    modport master (
        output start, abort, rom_data, act_data, act_valid, res_ready,
        input  busy, rom_adrs, act_ready, res_data, res_valid
    );

    modport slave (
        input  start, abort, rom_data, act_data, act_valid, res_ready,
        output busy, rom_adrs, act_ready, res_data, res_valid
    );
endinterface

`default_nettype wire

// File: rtl/w21_col_mac_seq.sv
// ============================================================================
// Module  : w21_col_mac_seq
// Brief   : Sweeps one W21 weight-ROM column, MACs it against streamed
//           activations and returns the dot product over valid/ready.
// Options : W21_MAC_SAT_EN - result is acc >>> FRAC_W saturated to DATA_W.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module w21_col_mac_seq #(
    parameter int DEPTH  = 300,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 21,
    parameter int ACC_W  = 51,
    parameter int FRAC_W = 10
) (
    input  wire logic        clk,
    input  wire logic        rst,
    w21_col_mac_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

    if (((1 << ADDR_W) < DEPTH) || (ACC_W < 2*DATA_W + $clog2(DEPTH)) || (FRAC_W >= ACC_W))
    begin : g_param_check
        $error("w21_col_mac_seq: inconsistent DEPTH/ADDR_W/ACC_W/FRAC_W");
    end

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [ADDR_W-1:0]          r_cnt;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [ACC_W-1:0]    r_prod_q;
    logic                       r_prod_v;
    logic signed [ACC_W-1:0]    r_res_hold;
    logic signed [ACC_W-1:0]    w_res_sel;
    logic signed [2*DATA_W-1:0] w_prod;
    logic                       w_act_ready;
    logic                       w_res_valid;
    logic                       w_busy;
    logic [ADDR_W-1:0]          w_adrs;
    logic                       w_start_pass;
    logic                       w_accept;
    logic                       w_abort_pass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_act_ready = 1'b0;
        w_res_valid = 1'b0;
        w_busy      = 1'b0;
        w_adrs      = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_act_ready = 1'b1;
                w_busy      = 1'b1;
                w_adrs      = r_cnt;
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.act_valid && (r_cnt == c_last)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy      = 1'b1;
                w_state_nxt = bus.abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                w_res_valid = 1'b1;
                if (bus.abort || bus.res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_start_pass = (r_state == S_IDLE) && bus.start && !bus.abort;
    assign w_accept     = w_act_ready && bus.act_valid && !bus.abort;
    assign w_abort_pass = (r_state != S_IDLE) && bus.abort;
    assign w_prod       = bus.act_data * bus.rom_data;

    // The final product is still in flight during DRAIN, so acc settles at DONE entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_prod_q   <= '0;
            r_prod_v   <= 1'b0;
            r_res_hold <= '0;
        end else begin
            if (r_prod_v) begin
                r_acc <= r_acc + r_prod_q;
            end
            if (w_start_pass) begin
                r_acc <= '0;
                r_cnt <= '0;
            end
            if (w_accept) begin
                r_prod_q <= {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
                r_prod_v <= 1'b1;
                r_cnt    <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
            end else begin
                r_prod_v <= 1'b0;
            end
            if (w_abort_pass) begin
                r_cnt <= '0;
            end
            if (r_state == S_DONE) begin
                r_res_hold <= w_res_sel;
            end
        end
    end

`ifdef W21_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] c_sat_max = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_sat_min = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] w_shift;

    always_comb begin
        w_shift = r_acc >>> FRAC_W;
        if (w_shift > c_sat_max) begin
            w_res_sel = c_sat_max;
        end else if (w_shift < c_sat_min) begin
            w_res_sel = c_sat_min;
        end else begin
            w_res_sel = w_shift;
        end
    end
`else
    assign w_res_sel = r_acc;
`endif

    // Outside DONE the last delivered result is held rather than the running sum.
    assign bus.res_data  = (r_state == S_DONE) ? w_res_sel : r_res_hold;
    assign bus.res_valid = w_res_valid;
    assign bus.act_ready = w_act_ready;
    assign bus.busy      = w_busy;
    assign bus.rom_adrs  = w_adrs;

endmodule

`default_nettype wire

// File: tb/tb_w21_col_mac_seq.sv
// ============================================================================
// Module  : tb_w21_col_mac_seq
// Brief   : Scoreboard bench for w21_col_mac_seq (raw or W21_MAC_SAT_EN build).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_w21_col_mac_seq;

    localparam int DEPTH  = 300;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 21;
    localparam int ACC_W  = 51;
    localparam int FRAC_W = 10;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    logic [ACC_W-1:0] exp_q[$];

    logic signed [DATA_W-1:0] rom_mem [DEPTH];
    logic signed [DATA_W-1:0] act_mem [DEPTH];

    w21_col_mac_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    w21_col_mac_seq #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .FRAC_W(FRAC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.rom_data = '0;
        if (int'(bus.rom_adrs) < DEPTH) begin
            bus.rom_data = rom_mem[bus.rom_adrs];
        end
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [ACC_W-1:0] model(input longint sum);
        longint s;
        s = sum;
`ifdef W21_MAC_SAT_EN
        s = sum >>> FRAC_W;
        if (s > longint'((1 << (DATA_W-1)) - 1)) s = longint'((1 << (DATA_W-1)) - 1);
        else if (s < -longint'(1 << (DATA_W-1))) s = -longint'(1 << (DATA_W-1));
`endif
        return s[ACC_W-1:0];
    endfunction

    // Result monitor: samples just ahead of the rising edge that completes the handshake.
    always begin
        logic [ACC_W-1:0] got;
        logic [ACC_W-1:0] exp;
        @(negedge clk);
        #4;
        if (!rst && bus.res_valid && bus.res_ready) begin
            got = bus.res_data;
            if (exp_q.size() == 0) begin
                check_value("unexpected_result", 64'(got), 64'hdead);
            end else begin
                exp = exp_q.pop_front();
                check_value("res_data", 64'(got), 64'(exp));
            end
        end
    end

    task automatic run_pass(input bit stall, input int stop_at, input bit use_rst, input bit hold);
        int     idx      = 0;
        int     guard    = 0;
        int     bad_adrs = 0;
        int     bad_busy = 0;
        int     bad_hold = 0;
        int     target;
        bit     tog      = 1'b0;
        longint sum      = 0;
        logic [ACC_W-1:0] held;

        target = (stop_at < 0) ? DEPTH : stop_at;
        for (int i = 0; i < DEPTH; i++) begin
            sum += longint'(rom_mem[i]) * longint'(act_mem[i]);
        end
        if (stop_at < 0) exp_q.push_back(model(sum));

        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        while (idx < target && guard < 4*DEPTH) begin
            tog = ~tog;
            bus.act_valid = stall ? tog : 1'b1;
            bus.act_data  = act_mem[idx];
            #4;
            if (!bus.busy || !bus.act_ready) bad_busy++;
            if (bus.act_valid && bus.act_ready) begin
                if (int'(bus.rom_adrs) != idx) bad_adrs++;
                idx++;
            end
            guard++;
            @(negedge clk);
        end
        bus.act_valid = 1'b0;
        check_value("accept_count", 64'(idx), 64'(target));
        check_value("rom_adrs_track", 64'(bad_adrs), 64'd0);
        check_value("busy_in_run", 64'(bad_busy), 64'd0);

        if (stop_at >= 0) begin
            if (use_rst) begin
                #2 rst = 1'b1;
                #1;
                check_value("rst_busy", 64'(bus.busy), 64'd0);
                check_value("rst_adrs", 64'(bus.rom_adrs), 64'd0);
                check_value("rst_res_valid", 64'(bus.res_valid), 64'd0);
                @(negedge clk);
                rst = 1'b0;
            end else begin
                bus.abort = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
                #4;
                check_value("abort_busy", 64'(bus.busy), 64'd0);
                check_value("abort_act_ready", 64'(bus.act_ready), 64'd0);
            end
            return;
        end

        // We are now in the cycle after the last accept (DRAIN).
        #4;
        check_value("drain_valid", 64'(bus.res_valid), 64'd0);
        check_value("drain_busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        #4;
        check_value("done_valid", 64'(bus.res_valid), 64'd1);
        check_value("done_busy", 64'(bus.busy), 64'd0);

        if (hold) begin
            held = bus.res_data;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                bus.start = (k == 3);
                #4;
                if (!bus.res_valid || (bus.res_data !== held)) bad_hold++;
            end
            bus.start = 1'b0;
            check_value("hold_stable", 64'(bad_hold), 64'd0);
            @(negedge clk);
            bus.res_ready = 1'b1;
            @(negedge clk);
            #4;
            check_value("release_valid", 64'(bus.res_valid), 64'd0);
            @(negedge clk);
            #4;
            check_value("start_ignored_busy", 64'(bus.busy), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.act_data  = '0;
        bus.act_valid = 1'b0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rom_mem[i] = 21'sd1;
            act_mem[i] = 21'sd1;
        end

        #12;
        check_value("reset_busy", 64'(bus.busy), 64'd0);
        check_value("reset_act_ready", 64'(bus.act_ready), 64'd0);
        check_value("reset_res_valid", 64'(bus.res_valid), 64'd0);
        check_value("reset_res_data", 64'(bus.res_data), 64'd0);
        check_value("reset_rom_adrs", 64'(bus.rom_adrs), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_pass(1'b0, -1, 1'b0, 1'b0);

        for (int i = 0; i < DEPTH; i++) begin
            rom_mem[i] = DATA_W'($urandom);
            act_mem[i] = '0;
        end
        rom_mem[0] = -21'sd181;
        act_mem[0] = 21'sd2;
        run_pass(1'b0, -1, 1'b0, 1'b0);

        for (int i = 0; i < DEPTH; i++) begin
            rom_mem[i] = DATA_W'($urandom);
            act_mem[i] = DATA_W'($urandom);
        end
        run_pass(1'b0, -1, 1'b0, 1'b0);
        run_pass(1'b1, -1, 1'b0, 1'b0);

        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        #4;
        check_value("start_abort_idle", 64'(bus.busy), 64'd0);

        bus.res_ready = 1'b0;
        run_pass(1'b0, -1, 1'b0, 1'b1);

        run_pass(1'b0, 150, 1'b0, 1'b0);
        run_pass(1'b0, -1, 1'b0, 1'b0);

        run_pass(1'b0, 150, 1'b1, 1'b0);
        run_pass(1'b0, -1, 1'b0, 1'b0);

        for (int i = 0; i < DEPTH; i++) begin
            rom_mem[i] = 21'sd524287;
            act_mem[i] = 21'sd524287;
        end
        run_pass(1'b0, -1, 1'b0, 1'b0);

        for (int i = 0; i < DEPTH; i++) begin
            rom_mem[i] = -21'sd1048576;
            act_mem[i] = 21'sd1048575;
        end
        run_pass(1'b0, -1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check_value("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
